// File: rtl/eth_pll_ctrl_pkg.sv
// Shared definitions for the Ethernet PLL power-up / lock supervisor.
package eth_pll_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    PWRDN     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } pll_state_t;

  // Largest of the three phase lengths, used to size the shared counter
  function automatic int cnt_max(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous status bit.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Resample the async input twice so downstream logic sees a settled level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/eth_pll_ctrl.sv
// Sequences PLL power-down, lock acquisition and lock qualification, and holds
// the Ethernet clock domain in reset until the PLL has been stable long enough.
module eth_pll_ctrl
  import eth_pll_ctrl_pkg::*;
#(
  parameter int PD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int STABLE_CYCLES = 256
) (
  input  logic               sys_clk_pad_i,
  input  logic               rst_n_pad_i,
  input  logic               pll_lock_i,
  input  logic               restart_i,
  output logic               pll_powerdown_n_o,
  output logic               eth_rst_o,
  output logic               pll_ok_o,
  output logic [7:0]         relock_cnt_o,
  output logic [STATE_W-1:0] state_o
);

  localparam int CNT_W = $clog2(cnt_max(PD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) + 1);

  localparam logic [CNT_W-1:0] PD_LOAD     = CNT_W'(PD_CYCLES);
  localparam logic [CNT_W-1:0] TO_LOAD     = CNT_W'(LOCK_TIMEOUT);
  localparam logic [CNT_W-1:0] STABLE_LOAD = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic             lock_s;
  pll_state_t       state;
  pll_state_t       nxt_state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] nxt_cnt;
  logic             fault_hit;

  sync2 u_lock_sync (
    .clk   (sys_clk_pad_i),
    .rst_n (rst_n_pad_i),
    .d     (pll_lock_i),
    .q     (lock_s)
  );

  // Next-state and shared-counter decode; restart wins over any fault condition
  always_comb begin
    nxt_state = state;
    nxt_cnt   = (cnt != '0) ? cnt - CNT_ONE : cnt;
    fault_hit = 1'b0;

    if (restart_i) begin
      nxt_state = PWRDN;
    end else begin
      case (state)
        PWRDN: begin
          if (cnt == CNT_ONE) nxt_state = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            nxt_state = STABLE;
          end else if (cnt == CNT_ONE) begin
            nxt_state = FAULT;
            fault_hit = 1'b1;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            nxt_state = FAULT;
            fault_hit = 1'b1;
          end else if (cnt == CNT_ONE) begin
            nxt_state = RUN;
          end
        end
        RUN: begin
          if (!lock_s) begin
            nxt_state = FAULT;
            fault_hit = 1'b1;
          end
        end
        FAULT:   nxt_state = PWRDN;
        default: nxt_state = PWRDN;
      endcase
    end

    if (restart_i || (nxt_state != state)) begin
      case (nxt_state)
        PWRDN:     nxt_cnt = PD_LOAD;
        WAIT_LOCK: nxt_cnt = TO_LOAD;
        STABLE:    nxt_cnt = STABLE_LOAD;
        default:   nxt_cnt = '0;
      endcase
    end
  end

  // State, counter and all outputs registered together so eth_rst_o is glitch-free
  always_ff @(posedge sys_clk_pad_i or negedge rst_n_pad_i) begin
    if (!rst_n_pad_i) begin
      state             <= PWRDN;
      cnt               <= PD_LOAD;
      pll_powerdown_n_o <= 1'b0;
      eth_rst_o         <= 1'b1;
      pll_ok_o          <= 1'b0;
      relock_cnt_o      <= 8'd0;
    end else begin
      state             <= nxt_state;
      cnt               <= nxt_cnt;
      pll_powerdown_n_o <= (nxt_state != PWRDN);
      eth_rst_o         <= (nxt_state != RUN);
      pll_ok_o          <= (nxt_state == RUN);
      if (fault_hit && (relock_cnt_o != 8'hFF)) begin
        relock_cnt_o <= relock_cnt_o + 8'd1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_eth_pll_ctrl.sv
// Directed self-checking bench for eth_pll_ctrl with short phase lengths.
module tb_eth_pll_ctrl;
  import eth_pll_ctrl_pkg::*;

  localparam int PD = 4;
  localparam int TO = 32;
  localparam int ST = 8;
  localparam int RETRY = TO + 1 + PD;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lock = 1'b0;
  logic       restart = 1'b0;
  logic       pd_n;
  logic       eth_rst;
  logic       ok;
  logic [7:0] relock;
  logic [2:0] state;

  int checks = 0;
  int failures = 0;

  eth_pll_ctrl #(
    .PD_CYCLES     (PD),
    .LOCK_TIMEOUT  (TO),
    .STABLE_CYCLES (ST)
  ) dut (
    .sys_clk_pad_i     (clk),
    .rst_n_pad_i       (rst_n),
    .pll_lock_i        (lock),
    .restart_i         (restart),
    .pll_powerdown_n_o (pd_n),
    .eth_rst_o         (eth_rst),
    .pll_ok_o          (ok),
    .relock_cnt_o      (relock),
    .state_o           (state)
  );

  // 100 MHz reference clock
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic l, input logic r);
    lock    = l;
    restart = r;
  endtask

  // Advance n clocks, leaving the bench 1 time unit past the last rising edge
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0);
    #12;
    checkOutput("rst_pd_n",   32'(pd_n),    32'd0);
    checkOutput("rst_eth",    32'(eth_rst), 32'd1);
    checkOutput("rst_ok",     32'(ok),      32'd0);
    checkOutput("rst_relock", 32'(relock),  32'd0);
    checkOutput("rst_state",  32'(state),   32'(PWRDN));

    // Power-up: PLL enabled after exactly PD cycles
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(PD - 1);
    checkOutput("pd_hold", 32'(pd_n), 32'd0);
    tick(1);
    checkOutput("pd_release", 32'(pd_n),  32'd1);
    checkOutput("wait_state", 32'(state), 32'(WAIT_LOCK));

    // Lock rises 10 cycles later; 2 sync + 1 decide, then ST cycles in STABLE
    tick(10);
    applyStimulus(1'b1, 1'b0);
    tick(3);
    checkOutput("stable_entry", 32'(state),   32'(STABLE));
    tick(ST - 1);
    checkOutput("stable_rst_held", 32'(eth_rst), 32'd1);
    tick(1);
    checkOutput("run_rst",    32'(eth_rst), 32'd0);
    checkOutput("run_ok",     32'(ok),      32'd1);
    checkOutput("run_relock", 32'(relock),  32'd0);

    // Lock loss in RUN: reset reasserted on the 3rd edge after the drop
    applyStimulus(1'b0, 1'b0);
    tick(2);
    checkOutput("drop_ok_still", 32'(ok), 32'd1);
    tick(1);
    checkOutput("drop_eth",    32'(eth_rst), 32'd1);
    checkOutput("drop_ok",     32'(ok),      32'd0);
    checkOutput("drop_state",  32'(state),   32'(FAULT));
    checkOutput("drop_relock", 32'(relock),  32'd1);
    tick(1);
    checkOutput("drop_pwrdn", 32'(pd_n), 32'd0);
    tick(PD - 1);
    checkOutput("relock_pd_hold", 32'(pd_n), 32'd0);
    tick(1);
    checkOutput("relock_pd_rel", 32'(pd_n), 32'd1);
    applyStimulus(1'b1, 1'b0);
    tick(3 + ST);
    checkOutput("relock_run", 32'(ok), 32'd1);

    // Restart coincident with the FSM seeing lock loss: no fault counted
    applyStimulus(1'b0, 1'b0);
    tick(2);
    applyStimulus(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("rs_state",  32'(state),   32'(PWRDN));
    checkOutput("rs_relock", 32'(relock),  32'd1);
    checkOutput("rs_eth",    32'(eth_rst), 32'd1);

    // Restart inside PWRDN reloads the power-down count
    tick(2);
    applyStimulus(1'b0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0);
    tick(PD - 1);
    checkOutput("pd_restart_hold", 32'(state), 32'(PWRDN));
    tick(1);
    checkOutput("pd_restart_done", 32'(state), 32'(WAIT_LOCK));

    // One-cycle lock glitch during STABLE
    applyStimulus(1'b1, 1'b0);
    tick(3);
    checkOutput("gl_stable", 32'(state), 32'(STABLE));
    tick(3);
    applyStimulus(1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0);
    tick(1);
    checkOutput("gl_still_stable", 32'(state), 32'(STABLE));
    tick(1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("gl_fault",  32'(state),   32'(FAULT));
    checkOutput("gl_relock", 32'(relock),  32'd2);
    checkOutput("gl_eth",    32'(eth_rst), 32'd1);

    // Lock never arrives: timeout after TO cycles in WAIT_LOCK, then retry
    tick(1 + PD);
    checkOutput("to_wait", 32'(state), 32'(WAIT_LOCK));
    tick(TO - 1);
    checkOutput("to_pre", 32'(state), 32'(WAIT_LOCK));
    tick(1);
    checkOutput("to_fault",  32'(state),  32'(FAULT));
    checkOutput("to_relock", 32'(relock), 32'd3);
    tick(1);
    checkOutput("to_pwrdn", 32'(pd_n), 32'd0);
    tick(PD - 1);
    checkOutput("to_pd_hold", 32'(pd_n), 32'd0);
    tick(1);
    checkOutput("to_retry", 32'(pd_n), 32'd1);

    // Repeated timeouts drive the counter into saturation
    tick(251 * RETRY);
    checkOutput("sat_254", 32'(relock), 32'd254);
    tick(RETRY);
    checkOutput("sat_255", 32'(relock), 32'd255);
    tick(48 * RETRY);
    checkOutput("sat_hold", 32'(relock), 32'd255);
    checkOutput("sat_state", 32'(state), 32'(WAIT_LOCK));

    // Asynchronous reset in the middle of STABLE
    applyStimulus(1'b1, 1'b0);
    tick(5);
    checkOutput("ar_stable", 32'(state), 32'(STABLE));
    rst_n = 1'b0;
    #1;
    checkOutput("ar_pd_n",   32'(pd_n),    32'd0);
    checkOutput("ar_eth",    32'(eth_rst), 32'd1);
    checkOutput("ar_ok",     32'(ok),      32'd0);
    checkOutput("ar_relock", 32'(relock),  32'd0);
    checkOutput("ar_state",  32'(state),   32'(PWRDN));

    // Recovery after reset with lock already present
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(PD + 1);
    checkOutput("rec_stable", 32'(state), 32'(STABLE));
    tick(ST);
    checkOutput("rec_run", 32'(ok), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
